shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares a single W-bit storage register (q/qbar pair) among four requesters. Each requester gains exclusive write ownership through a req/gnt handshake and may write up to MAX_BURST consecutive words before ownership is forcibly rotated. It sits between the requesting agents and the shared flip-flop bank, sequencing every update of that bank.

## Interface
- W, 8, data width of the shared register and of each requester's write slice
- MAX_BURST, 4, max writes per grant (≥1); counter width is clog2(MAX_BURST)+1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-requester request; bit i held high while requester i wants to write
- wdata  in  4*W  write data; requester i drives wdata[i*W +: W]
- gnt  out  4  one-hot grant, registered; all-zero when no owner
- owner  out  2  index of current/last owner, registered
- q  out  W  shared register contents
- qbar  out  W  bitwise complement of q, always
- wr_stb  out  1  registered; high for the cycle following each edge at which q was written
- busy  out  1  high while state is ACTIVE (equals |gnt)

## Operation
- Internal state: fsm {IDLE, ACTIVE}, rotation pointer ptr[1:0], burst counter bcnt.
- Reset (asynchronous, immediate): fsm=IDLE, ptr=0, bcnt=0, gnt=0, owner=0, q=0, qbar=all ones, wr_stb=0, busy=0.
- Arbitration (IDLE, req≠0): winner = first set bit of req scanning ptr, ptr+1, … mod 4. At that edge: gnt<=onehot(winner), owner<=winner, bcnt<=0, fsm<=ACTIVE. No write occurs in IDLE.
- IDLE with req=0: hold; gnt stays 0.
- ACTIVE, req[owner]=1: q<=wdata slice of owner, qbar<=~slice, wr_stb<=1, bcnt<=bcnt+1. If bcnt==MAX_BURST-1 (this is the last allowed write): gnt<=0, fsm<=IDLE, ptr<=owner+1 mod 4.
- ACTIVE, req[owner]=0: no write, wr_stb<=0, gnt<=0, fsm<=IDLE, ptr<=owner+1 mod 4 (a grant with zero writes still rotates).
- Requests from non-owners during ACTIVE are ignored; they are sampled only in IDLE.
- q/qbar hold their value whenever no write occurs; qbar==~q is an invariant, including reset.
- owner keeps the last owner's index after release until the next grant.

## Timing
- req rising before edge k (fsm IDLE) -> gnt visible after edge k.
- First write at edge k+1 if req[owner] still high; q visible after k+1, wr_stb high in cycle k+1..k+2.
- Continuous requesters: MAX_BURST writes then one IDLE re-arbitration cycle; grant period = MAX_BURST+1 cycles, write duty MAX_BURST/(MAX_BURST+1).
- On the last burst edge, the write and the gnt deassertion happen at the same edge.
- wdata is sampled at the write edge, not at the grant edge.
- Reset asserted mid-burst: all outputs clear without waiting for clk; after deassertion first grant uses ptr=0.
- MAX_BURST=1: every grant performs exactly one write, period 2 cycles.

## Test plan
- Reset: rst_n=0 with clk stopped -> q=0x00, qbar=0xFF, gnt=0000, owner=0, busy=0, wr_stb=0.
- Single requester: req=0100, slice2=0xA5 for 2 writes then req=0 -> gnt=0100 one edge after req; q=0xA5, qbar=0x5A; wr_stb high 2 cycles; gnt=0000 at the edge req is seen low.
- Full load, MAX_BURST=4, req=1111 held, each slice distinct -> grant order 0,1,2,3,0; per owner exactly 4 wr_stb pulses then 1 idle cycle; q tracks slice of current owner.
- Rotation: owner 1 releases, then req=1010 -> next gnt=1000 (requester 3 before 1 because ptr=2).
- Zero-write grant: req[0] pulses one cycle -> gnt=0001 for one cycle, no wr_stb, q unchanged, ptr advances to 1.
- Async reset after second write of a burst -> q=0x00, qbar=0xFF, gnt=0000 immediately; with req=1111 after release, first gnt=0001.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting four requesters exclusive, burst-limited write
// access to one shared W-bit register (q with its complement qbar).
module shared_reg_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] wdata,
  output logic [3:0]     gnt,
  output logic [1:0]     owner,
  output logic [W-1:0]   q,
  output logic [W-1:0]   qbar,
  output logic           wr_stb,
  output logic           busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CntW-1:0] bcnt_q, bcnt_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      owner_q, owner_d;
  logic [W-1:0]    data_q, data_d;
  logic            wr_stb_q, wr_stb_d;

  logic [1:0]      win;
  logic [W-1:0]    wslice;

  // Scan from the highest offset down so the set bit nearest ptr wins last.
  always_comb begin
    win = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
  end

  assign wslice = wdata[owner_q*W +: W];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bcnt_d   = bcnt_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    data_d   = data_q;
    wr_stb_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = 4'b0001 << win;
          owner_d = win;
          bcnt_d  = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        if (req[owner_q]) begin
          data_d   = wslice;
          wr_stb_d = 1'b1;
          bcnt_d   = bcnt_q + CntW'(1);
          if (bcnt_q == LastCnt) begin
            gnt_d   = '0;
            state_d = StIdle;
            ptr_d   = owner_q + 2'd1;
          end
        end else begin
          // Owner dropped its request: release, still rotating past it.
          gnt_d   = '0;
          state_d = StIdle;
          ptr_d   = owner_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      bcnt_q   <= '0;
      gnt_q    <= '0;
      owner_q  <= '0;
      data_q   <= '0;
      wr_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      bcnt_q   <= bcnt_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  assign gnt    = gnt_q;
  assign owner  = owner_q;
  assign q      = data_q;
  assign qbar   = ~data_q;
  assign wr_stb = wr_stb_q;
  assign busy   = (state_q == StActive);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scenario-driven bench for shared_reg_arbiter; expected write data is queued
// as stimulus is applied and popped whenever wr_stb reports a write.
module tb_shared_reg_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           clk_en = 1'b0;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] wdata;
  logic [3:0]     gnt;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic [W-1:0]   qbar;
  logic           wr_stb;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  shared_reg_arbiter #(.W(W), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .owner  (owner),
    .q      (q),
    .qbar   (qbar),
    .wr_stb (wr_stb),
    .busy   (busy)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    #2;
    n_checks++;
    if (q !== 8'h00 || qbar !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_q: got q=%h qbar=%h want q=00 qbar=ff", q, qbar);
    end
    n_checks++;
    if (gnt !== 4'b0000 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_gnt: got gnt=%b owner=%0d want 0000/0", gnt, owner);
    end
    n_checks++;
    if (busy !== 1'b0 || wr_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b wr_stb=%b want 0/0", busy, wr_stb);
    end
    #1;
    rst_n  = 1'b1;
    clk_en = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [W-1:0] e;
    req = 4'b0100;
    wdata[2*W +: W] = 8'hA5;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    step();
    n_checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1 || wr_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b owner=%0d busy=%b stb=%b want 0100/2/1/0",
               gnt, owner, busy, wr_stb);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (wr_stb !== 1'b1 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL single_stb%0d: got wr_stb=%b want 1", i, wr_stb);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (q !== e || qbar !== ~e) begin
          n_fail++;
          $display("FAIL single_q%0d: got q=%h qbar=%h want %h/%h", i, q, qbar, e, ~e);
        end
      end
    end
    req = 4'b0000;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || wr_stb !== 1'b0 || busy !== 1'b0 || q !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%b stb=%b busy=%b q=%h want 0000/0/0/a5",
               gnt, wr_stb, busy, q);
    end
  endtask

  task automatic test_full_load();
    logic [W-1:0] e;
    logic [3:0]   eg;
    logic         es;
    int           ow;
    int           nstb = 0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < MB; k++) exp_q.push_back(wdata[(g % 4)*W +: W]);
    end
    for (int c = 1; c <= 25; c++) begin
      step();
      ow = ((c - 1) / 5) % 4;
      eg = (c % 5 == 0) ? 4'b0000 : (4'b0001 << ow);
      es = (c % 5 != 1);
      n_checks++;
      if (gnt !== eg || wr_stb !== es || owner !== 2'(ow)) begin
        n_fail++;
        $display("FAIL full_cycle%0d: got gnt=%b stb=%b owner=%0d want %b/%b/%0d",
                 c, gnt, wr_stb, owner, eg, es, ow);
      end
      if (wr_stb === 1'b1) begin
        nstb++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_checks++;
          if (q !== e) begin
            n_fail++;
            $display("FAIL full_q%0d: got q=%h want %h", c, q, e);
          end
        end
      end
    end
    n_checks++;
    if (nstb != 20 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes, %0d pending want 20/0", nstb, exp_q.size());
    end
  endtask

  task automatic test_rotation();
    req = 4'b0010;
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL rot_grant1: got gnt=%b want 0010", gnt);
    end
    req = 4'b0000;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || wr_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL rot_release: got gnt=%b stb=%b want 0000/0", gnt, wr_stb);
    end
    req = 4'b1010;
    step();
    n_checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      n_fail++;
      $display("FAIL rot_grant3: got gnt=%b owner=%0d want 1000/3", gnt, owner);
    end
    req = 4'b0000;
    step();
    n_checks++;
    if (busy !== 1'b0 || owner !== 2'd3) begin
      n_fail++;
      $display("FAIL rot_idle: got busy=%b owner=%0d want 0/3", busy, owner);
    end
  endtask

  task automatic test_zero_write();
    logic [W-1:0] qsave;
    qsave = q;
    req = 4'b0001;
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL zw_grant: got gnt=%b want 0001", gnt);
    end
    req = 4'b0000;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || wr_stb !== 1'b0 || q !== qsave) begin
      n_fail++;
      $display("FAIL zw_release: got gnt=%b stb=%b q=%h want 0000/0/%h", gnt, wr_stb, q, qsave);
    end
    req = 4'b0011;
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL zw_ptr: got gnt=%b want 0010", gnt);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req   = 4'b1111;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC3);
    step();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL ar_grant: got gnt=%b want 0100", gnt);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (wr_stb !== 1'b1 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ar_stb%0d: got wr_stb=%b want 1", i, wr_stb);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (q !== e) begin
          n_fail++;
          $display("FAIL ar_q%0d: got q=%h want %h", i, q, e);
        end
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (q !== 8'h00 || qbar !== 8'hFF || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL ar_clear: got q=%h qbar=%h gnt=%b want 00/ff/0000", q, qbar, gnt);
    end
    n_checks++;
    if (busy !== 1'b0 || wr_stb !== 1'b0 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL ar_flags: got busy=%b stb=%b owner=%0d want 0/0/0", busy, wr_stb, owner);
    end
    #2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL ar_regrant: got gnt=%b want 0001", gnt);
    end
    req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_load();
    test_rotation();
    test_zero_write();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
